// File: rtl/dbus_peri_bridge_pkg.sv
// Shared peripheral package: data-bus request/response structs, bridge FSM states,
// timeout fill pattern and the GPIO register map (gpio_defs).
package dbus_peri_bridge_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
    logic        err;
  } type_peri2dbus_s;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bridge_state_e;

  localparam logic [31:0] PERI_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // gpio_defs: register offsets inside a GPIO slot
  localparam int          GPIO_WIDTH    = 32;
  localparam logic [11:0] GPIO_REG_DIN  = 12'h000;
  localparam logic [11:0] GPIO_REG_DOUT = 12'h004;
  localparam logic [11:0] GPIO_REG_DIR  = 12'h008;

endpackage

// File: rtl/dbus_peri_bridge_timer.sv
// peri_bus_timer: saturating wait-cycle counter; expired_o flags the LIMIT-th enabled cycle.
module peri_bus_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CW'(LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of earlier enabled cycles, so this is the LIMIT-th one
  assign expired_o = enable_i && (count_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/dbus_peri_bridge.sv
// Core data-bus to peripheral-slot bridge (IDLE/ISSUE/WAIT/RESP).
// Optional ack timeout is built only when PERI_TIMEOUT_EN is defined.
module dbus_peri_bridge
  import dbus_peri_bridge_pkg::*;
#(
  parameter int NUM_PERI     = 4,
  parameter int PERI_SEL_LSB = 12,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  type_dbus2peri_s lsu2bridge_i,
  output type_peri2dbus_s bridge2lsu_o,
  output type_dbus2peri_s dbus2peri_o,
  output logic [NUM_PERI-1:0] peri_sel_o,
  input  type_peri2dbus_s peri2dbus_i [NUM_PERI],
  output bridge_state_e   dbg_state_o
);
  // Handshake: the core raises req in IDLE and holds it until a one-cycle ack;
  // each peripheral sees a one-cycle req with its select and answers with ack.
  localparam int SEL_W = (NUM_PERI > 1) ? $clog2(NUM_PERI) : 1;

  bridge_state_e    state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       sel_byte_q, sel_byte_d;
  logic             w_en_q, w_en_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [31:0]      r_data_q, r_data_d;
  logic             err_q, err_d;

  // Every address bit above PERI_SEL_LSB takes part in the decode, so pages past
  // the last slot are unmapped instead of aliasing onto a real slot.
  logic [31:0] req_page;
  logic        req_mapped;
  assign req_page   = lsu2bridge_i.addr >> PERI_SEL_LSB;
  assign req_mapped = req_page < 32'(NUM_PERI);

  logic        sel_ack;
  logic [31:0] sel_rdata;
  logic        peri_err_unused;

  always_comb begin
    sel_ack         = 1'b0;
    sel_rdata       = '0;
    peri_err_unused = 1'b0;
    for (int i = 0; i < NUM_PERI; i++) begin
      peri_err_unused = peri_err_unused ^ peri2dbus_i[i].err;
      if (slot_q == SEL_W'(i)) begin
        sel_ack   = peri2dbus_i[i].ack;
        sel_rdata = peri2dbus_i[i].r_data;
      end
    end
  end

  logic tmo_expired;
`ifdef PERI_TIMEOUT_EN
  logic tmo_en, tmo_clr;
  assign tmo_en  = (state_q == WAIT);
  assign tmo_clr = (state_q != WAIT);

  peri_bus_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmo_clr),
    .enable_i (tmo_en),
    .expired_o(tmo_expired)
  );
`else
  localparam int TIMEOUT_CYC_UNUSED = TIMEOUT_CYC;
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    w_data_d   = w_data_q;
    sel_byte_d = sel_byte_q;
    w_en_d     = w_en_q;
    slot_d     = slot_q;
    r_data_d   = r_data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (lsu2bridge_i.req) begin
          addr_d     = lsu2bridge_i.addr;
          w_data_d   = lsu2bridge_i.w_data;
          sel_byte_d = lsu2bridge_i.sel_byte;
          w_en_d     = lsu2bridge_i.w_en;
          slot_d     = lsu2bridge_i.addr[PERI_SEL_LSB +: SEL_W];
          r_data_d   = '0;
          err_d      = !req_mapped;
          state_d    = req_mapped ? ISSUE : RESP;
        end
      end
      ISSUE, WAIT: begin
        // An ack coinciding with expiry wins
        if (sel_ack) begin
          r_data_d = w_en_q ? '0 : sel_rdata;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (tmo_expired) begin
          r_data_d = PERI_TIMEOUT_RDATA;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      w_data_q   <= '0;
      sel_byte_q <= '0;
      w_en_q     <= 1'b0;
      slot_q     <= '0;
      r_data_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      w_data_q   <= w_data_d;
      sel_byte_q <= sel_byte_d;
      w_en_q     <= w_en_d;
      slot_q     <= slot_d;
      r_data_q   <= r_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    dbus2peri_o  = '0;
    peri_sel_o   = '0;
    bridge2lsu_o = '0;
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      dbus2peri_o.addr     = addr_q;
      dbus2peri_o.w_data   = w_data_q;
      dbus2peri_o.sel_byte = sel_byte_q;
      dbus2peri_o.w_en     = w_en_q;
      dbus2peri_o.req      = (state_q == ISSUE);
      for (int i = 0; i < NUM_PERI; i++) begin
        peri_sel_o[i] = (slot_q == SEL_W'(i));
      end
    end
    if (state_q == RESP) begin
      bridge2lsu_o.ack    = 1'b1;
      bridge2lsu_o.r_data = r_data_q;
      bridge2lsu_o.err    = err_q;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dbus_peri_bridge.sv
// Bench for dbus_peri_bridge: vector table plus reset, stray-ack and timeout sequences.
module tb_dbus_peri_bridge;
  import dbus_peri_bridge_pkg::*;

  localparam int NP = 4;

  logic            clk;
  logic            rst_n;
  type_dbus2peri_s lsu_req;
  type_peri2dbus_s lsu_rsp;
  type_dbus2peri_s dbus_req;
  logic [NP-1:0]   peri_sel;
  type_peri2dbus_s peri_rsp [NP];
  bridge_state_e   dbg_state;

  dbus_peri_bridge #(
    .NUM_PERI    (NP),
    .PERI_SEL_LSB(12),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu2bridge_i(lsu_req),
    .bridge2lsu_o(lsu_rsp),
    .dbus2peri_o (dbus_req),
    .peri_sel_o  (peri_sel),
    .peri2dbus_i (peri_rsp),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    int          d;
    logic [31:0] p_rdata;
    logic        noise;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(logic [31:0] addr, logic [31:0] wd, logic [3:0] sb, logic we,
                              int d, logic [31:0] prd, logic noise, logic eerr,
                              logic [31:0] erd, logic [3:0] esel, int elat);
    vec_t v;
    v.addr = addr; v.w_data = wd; v.sel_byte = sb; v.w_en = we; v.d = d;
    v.p_rdata = prd; v.noise = noise; v.exp_err = eerr; v.exp_rdata = erd;
    v.exp_sel = esel; v.exp_lat = elat;
    return v;
  endfunction

  // reference decode for generated vectors
  function automatic vec_t model(logic [31:0] addr, logic [31:0] wd, logic we, int d,
                                 logic [31:0] prd);
    int page;
    page = int'(addr >> 12);
    if (page >= NP) return mk(addr, wd, 4'hF, we, d, prd, 1'b0, 1'b1, 32'h0, 4'h0, 1);
    return mk(addr, wd, 4'hF, we, d, prd, 1'b0, 1'b0, we ? 32'h0 : prd,
              4'(1 << page), 2 + d);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic clear_peri();
    for (int i = 0; i < NP; i++) peri_rsp[i] = '0;
  endtask

  // scoreboard: every core ack pops one expected {err, r_data}
  always @(negedge clk) begin
    if (rst_n && lsu_rsp.ack) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got r_data %h err %b, expected no ack",
                 lsu_rsp.r_data, lsu_rsp.err);
      end else begin
        check("resp_data", {31'b0, lsu_rsp.err, lsu_rsp.r_data}, {31'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int cyc, lat, reqs, slot, noise_slot;
    bit seen;
    slot = int'(v.addr[13:12]);
    noise_slot = (slot + 1) % NP;
    @(negedge clk);
    lsu_req.addr = v.addr; lsu_req.w_data = v.w_data; lsu_req.sel_byte = v.sel_byte;
    lsu_req.w_en = v.w_en; lsu_req.req = 1'b1;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    cyc = 0; lat = 0; reqs = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      clear_peri();
      if (dbus_req.req) reqs++;
      if (lsu_rsp.ack) begin
        seen = 1; lat = cyc;
        lsu_req.req = 1'b0;
        check("sel_in_resp", 64'(peri_sel), 64'h0);
      end else begin
        check("peri_sel", 64'(peri_sel), 64'(v.exp_sel));
        check("bus_fields", {dbus_req.addr, dbus_req.w_data[26:0], dbus_req.sel_byte, dbus_req.w_en},
              {v.addr, v.w_data[26:0], v.sel_byte, v.w_en});
        if (cyc == 1 + v.d) begin
          peri_rsp[slot].ack = 1'b1;
          peri_rsp[slot].r_data = v.p_rdata;
        end
        if (v.noise && cyc == 1) begin
          peri_rsp[noise_slot].ack = 1'b1;
          peri_rsp[noise_slot].r_data = 32'h0000_0BAD;
        end
      end
    end
    clear_peri();
    lsu_req.req = 1'b0;
    check("ack_seen", 64'(seen), 64'h1);
    check("ack_latency", 64'(lat), 64'(v.exp_lat));
    check("issue_pulses", 64'(reqs), (v.exp_sel != 0) ? 64'h1 : 64'h0);
  endtask

  vec_t vecs[11];

  initial begin
    lsu_req = '0;
    clear_peri();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp", 64'(lsu_rsp), 64'h0);
    check("reset_bus", 64'(dbus_req), 64'h0);
    check("reset_sel", 64'(peri_sel), 64'h0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;

    vecs[0] = mk(32'h0000_0004, 32'h0, 4'hF, 1'b0, 2, 32'h0000_00A5, 1'b0, 1'b0, 32'h0000_00A5, 4'b0001, 4);
    vecs[1] = mk(32'h0000_2008, 32'h0000_1234, 4'b0011, 1'b1, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 4'b0100, 3);
    vecs[2] = mk(32'h0000_5000, 32'h0, 4'hF, 1'b0, 0, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0000, 1);
    vecs[3] = mk(32'h0000_3010, 32'h0, 4'hF, 1'b0, 0, 32'h1357_9BDF, 1'b0, 1'b0, 32'h1357_9BDF, 4'b1000, 2);
    vecs[4] = mk(32'h0000_0000, 32'h0, 4'hF, 1'b0, 3, 32'h0000_0055, 1'b1, 1'b0, 32'h0000_0055, 4'b0001, 5);
    vecs[5] = mk(32'h0000_1FFC, 32'h0, 4'hF, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 4'b0010, 3);
    vecs[6] = mk(32'hFFFF_F000, 32'h0, 4'hF, 1'b1, 0, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0000, 1);
    for (int i = 7; i < 11; i++) begin
      vecs[i] = model((32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 1023)) << 2),
                      $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom);
    end
    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // reset while a slot-0 read sits in WAIT, then a late ack from that slot
    @(negedge clk);
    lsu_req.addr = 32'h0000_0010; lsu_req.w_en = 1'b0; lsu_req.sel_byte = 4'hF; lsu_req.req = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_sel", 64'(peri_sel), 64'h1);
    rst_n = 1'b0;
    lsu_req.req = 1'b0;
    #1;
    check("async_rst_sel", 64'(peri_sel), 64'h0);
    check("async_rst_bus", 64'(dbus_req), 64'h0);
    check("async_rst_rsp", 64'(lsu_rsp), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    peri_rsp[0].ack = 1'b1;
    peri_rsp[0].r_data = 32'h77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clear_peri();
      check("late_ack_rsp", 64'(lsu_rsp), 64'h0);
      check("late_ack_sel", 64'(peri_sel), 64'h0);
    end
    run_txn(mk(32'h0000_1020, 32'h0, 4'hF, 1'b0, 1, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0000_BEEF, 4'b0010, 3));

`ifdef PERI_TIMEOUT_EN
    run_txn(mk(32'h0000_1000, 32'h0, 4'hF, 1'b0, 1000, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0010, 10));
    run_txn(mk(32'h0000_1000, 32'h0, 4'hF, 1'b0, 8, 32'h0000_0042, 1'b0, 1'b0, 32'h0000_0042, 4'b0010, 10));
    run_txn(mk(32'h0000_3000, 32'h0, 4'hF, 1'b0, 7, 32'h0000_0099, 1'b0, 1'b0, 32'h0000_0099, 4'b1000, 9));
`endif

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
